// File: rtl/rotate_sched_pkg.sv
// Shared types and engine timing constants for the rotate scheduler.
// Imported by the round-robin picker and the scheduler top.
package rotate_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int ENG_ITERATIONS = 12;
  localparam int ENG_LATENCY    = ENG_ITERATIONS + 2;

endpackage

// File: rtl/rotate_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, reported as one-hot grant, binary index and any-flag.
module rr_picker
  import rotate_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/rotate_scheduler.sv
// Shares one CORDIC rotate engine among NUM_REQ requesters with
// round-robin arbitration and a valid/ready result port.
module rotate_scheduler
  import rotate_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int VEC_WIDTH = 7,
  parameter int ANG_WIDTH = 9,
  parameter int ID_WIDTH  = $clog2(NUM_REQ),
  parameter int TIMEOUT   = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*VEC_WIDTH-1:0]   i_x,
  input  logic [NUM_REQ*VEC_WIDTH-1:0]   i_y,
  input  logic [NUM_REQ*ANG_WIDTH-1:0]   i_angle,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [ID_WIDTH-1:0]            o_id,
  output logic [VEC_WIDTH-1:0]           o_x,
  output logic [VEC_WIDTH-1:0]           o_y,
  output logic                           o_err,
  output logic                           o_eng_start,
  output logic [VEC_WIDTH-1:0]           o_eng_x,
  output logic [VEC_WIDTH-1:0]           o_eng_y,
  output logic [ANG_WIDTH-1:0]           o_eng_angle,
  input  logic [VEC_WIDTH-1:0]           i_eng_x,
  input  logic [VEC_WIDTH-1:0]           i_eng_y,
  input  logic                           i_eng_done
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [VEC_WIDTH-1:0]  opx_q, opx_d;
  logic [VEC_WIDTH-1:0]  opy_q, opy_d;
  logic [ANG_WIDTH-1:0]  opa_q, opa_d;
  logic [VEC_WIDTH-1:0]  rx_q, rx_d;
  logic [VEC_WIDTH-1:0]  ry_q, ry_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_WIDTH-1:0]   gidx;
  logic                  gany;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    opx_d   = opx_q;
    opy_d   = opy_q;
    opa_d   = opa_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (gany) begin
          id_d    = gidx;
          opx_d   = i_x[gidx*VEC_WIDTH +: VEC_WIDTH];
          opy_d   = i_y[gidx*VEC_WIDTH +: VEC_WIDTH];
          opa_d   = i_angle[gidx*ANG_WIDTH +: ANG_WIDTH];
          ptr_d   = (gidx == ID_WIDTH'(NUM_REQ - 1)) ?
                    '0 : gidx + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (i_eng_done) begin
          rx_d    = i_eng_x;
          ry_d    = i_eng_y;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_d == CW'(TIMEOUT - 1)) begin
          // engine never answered: report an error with zeroed result
          rx_d    = '0;
          ry_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      opx_q   <= '0;
      opy_q   <= '0;
      opa_q   <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      opx_q   <= opx_d;
      opy_q   <= opy_d;
      opa_q   <= opa_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ack       = (state_q == S_IDLE) ? gnt : '0;
  assign o_eng_start = (state_q == S_ISSUE);
  assign o_valid     = (state_q == S_RESP);
  assign o_id        = id_q;
  assign o_x         = rx_q;
  assign o_y         = ry_q;
  assign o_err       = err_q;
  assign o_eng_x     = opx_q;
  assign o_eng_y     = opy_q;
  assign o_eng_angle = opa_q;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Scoreboard bench for rotate_scheduler with a behavioural rotate
// engine, an arbitration reference model and a result monitor.
module tb_rotate_scheduler;

  localparam int N    = 4;
  localparam int VW   = 7;
  localparam int AW   = 9;
  localparam int IW   = 2;
  localparam int TO   = 64;
  localparam int ITER = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*VW-1:0] xs, ys;
  logic [N*AW-1:0] angs;
  logic [N-1:0]    ack;
  logic            valid, ready;
  logic [IW-1:0]   id;
  logic [VW-1:0]   ox, oy;
  logic            err, es;
  logic [VW-1:0]   ex, ey, eix, eiy;
  logic [AW-1:0]   eang;
  logic            edone;

  rotate_scheduler #(
    .NUM_REQ(N), .VEC_WIDTH(VW), .ANG_WIDTH(AW),
    .ID_WIDTH(IW), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_x(xs), .i_y(ys), .i_angle(angs),
    .o_ack(ack), .o_valid(valid), .i_ready(ready),
    .o_id(id), .o_x(ox), .o_y(oy), .o_err(err),
    .o_eng_start(es), .o_eng_x(ex), .o_eng_y(ey),
    .o_eng_angle(eang), .i_eng_x(eix), .i_eng_y(eiy),
    .i_eng_done(edone)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name,
               $signed(act), $signed(exp));
    end
  endtask

  function automatic int rnd(real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic int rot_x(int x, int y, int a);
    real r;
    r = a * 3.141592653589793 / 180.0;
    return rnd(x * $cos(r) - y * $sin(r));
  endfunction

  function automatic int rot_y(int x, int y, int a);
    real r;
    r = a * 3.141592653589793 / 180.0;
    return rnd(x * $sin(r) + y * $cos(r));
  endfunction

  // behavioural engine: answers ITER+1 cycles after start unless hung
  int   eng_cnt;
  logic eng_busy;
  logic eng_hang = 1'b0;
  logic inj_done = 1'b0;
  logic [AW-1:0] ang_ref;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
      ang_ref  <= '0;
    end else if (es) begin
      eng_busy <= 1'b1;
      eng_cnt  <= ITER;
      ang_ref  <= eang;
    end else if (eng_busy) begin
      if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
      else if (!eng_hang) eng_busy <= 1'b0;
    end
  end

  always_comb begin
    eix   = VW'(rot_x(int'($signed(ex)), int'($signed(ey)),
                      int'($signed(eang))));
    eiy   = VW'(rot_y(int'($signed(ex)), int'($signed(ey)),
                      int'($signed(eang))));
    edone = (eng_busy && eng_cnt == 0 && !eng_hang) || inj_done;
    if (inj_done) begin
      eix = 7'd17;
      eiy = 7'd23;
    end
  end

  always @(negedge clk) begin
    if (rst_n && eng_busy && !eng_hang)
      chk("eng_angle_stable", eang, ang_ref);
  end

  // reference model: arbitration and expected results
  typedef struct {
    int id;
    int x;
    int y;
    bit err;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   ack_log[$];
  int   ack_cyc[$];
  int   ptr      = 0;
  bit   busy     = 0;
  int   resp_cyc = 0;
  int   hang_mode = 0;
  bit   gflag[N];
  int   mg, mk, sx, sy, sa;
  bit   mh;
  logic [N-1:0] exp_ack;
  exp_t me;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_ack = '0;
      mg = -1;
      if (!busy)
        for (int i = 0; i < N; i++) begin
          mk = (ptr + i) % N;
          if (mg < 0 && req[mk]) mg = mk;
        end
      if (mg >= 0) exp_ack[mg] = 1'b1;
      chk("ack", ack, exp_ack);
      if (busy) begin
        if (cyc >= resp_cyc && ready) busy = 0;
      end else if (mg >= 0) begin
        mh = (hang_mode == 1) ||
             (hang_mode == 2 && $urandom_range(0, 7) == 0);
        sx = int'($signed(xs[mg*VW +: VW]));
        sy = int'($signed(ys[mg*VW +: VW]));
        sa = int'($signed(angs[mg*AW +: AW]));
        me.id  = mg;
        me.err = mh;
        me.x   = mh ? 0 : rot_x(sx, sy, sa);
        me.y   = mh ? 0 : rot_y(sx, sy, sa);
        me.cyc = mh ? cyc + 1 + TO : cyc + ITER + 3;
        q.push_back(me);
        resp_cyc  = me.cyc;
        busy      = 1;
        ptr       = (mg + 1) % N;
        eng_hang  = mh;
        gflag[mg] = 1;
        ack_log.push_back(mg);
        ack_cyc.push_back(cyc);
      end
    end
  end

  // monitor: compares every presented result against the queue head
  bit prev_v = 0;
  int last_id, last_x, last_y;
  bit last_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      if (valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", valid, 1'b0);
        end else begin
          if (!prev_v) chk("latency", cyc, q[0].cyc);
          chk("id", id, q[0].id);
          chk("x", int'($signed(ox)), q[0].x);
          chk("y", int'($signed(oy)), q[0].y);
          chk("err", err, q[0].err);
          if (ready) begin
            last_id  = int'(id);
            last_x   = int'($signed(ox));
            last_y   = int'($signed(oy));
            last_err = err;
            void'(q.pop_front());
          end
        end
      end else if (q.size() > 0 && cyc >= q[0].cyc) begin
        chk("valid_missing", valid, 1'b1);
      end
      prev_v = valid && !ready;
    end
  end

  // stimulus
  bit drop_all = 1;
  bit drop_rnd = 0;
  bit rnd_on   = 0;

  task automatic set_op(int k, int x, int y, int a);
    xs[k*VW +: VW]   = VW'(x);
    ys[k*VW +: VW]   = VW'(y);
    angs[k*AW +: AW] = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++)
      if (gflag[k]) begin
        gflag[k] = 0;
        if (drop_all || (drop_rnd && $urandom_range(0, 1) == 0))
          req[k] = 1'b0;
      end
    if (rnd_on) begin
      for (int k = 0; k < N; k++)
        if (!req[k] && $urandom_range(0, 3) == 0) begin
          set_op(k, int'($urandom_range(0, 80)) - 40,
                 int'($urandom_range(0, 80)) - 40,
                 int'($urandom_range(0, 360)) - 180);
          req[k] = 1'b1;
        end
      ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_grants(int n, int lim);
    int c = 0;
    while (ack_log.size() < n && c < lim) begin
      tick();
      c++;
    end
    chk("grant_wait", ack_log.size() >= n, 1'b1);
  endtask

  task automatic wait_valid(int lim);
    int c = 0;
    while (!valid && c < lim) begin
      tick();
      c++;
    end
    chk("valid_wait", valid, 1'b1);
  endtask

  task automatic wait_idle(int lim);
    int c = 0;
    while ((q.size() != 0 || busy || req != 0) && c < lim) begin
      tick();
      c++;
    end
    chk("idle_wait", q.size() == 0 && !busy, 1'b1);
  endtask

  task automatic check_reset_outputs();
    chk("reset_outputs",
        {ack, valid, id, ox, oy, err, es, ex, ey, eang}, 64'd0);
  endtask

  task automatic clear_model();
    q.delete();
    ack_log.delete();
    ack_cyc.delete();
    busy = 0;
    ptr  = 0;
    req  = '0;
    for (int k = 0; k < N; k++) gflag[k] = 0;
  endtask

  task automatic pulse_reset();
    tick();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int exp6[6] = '{0, 1, 2, 3, 0, 1};
  int exp3[3] = '{3, 1, 3};
  int rel;

  initial begin
    rst_n = 1'b1;
    req   = '0;
    xs    = '0;
    ys    = '0;
    angs  = '0;
    ready = 1'b1;
    #1 rst_n = 1'b0;
    #10 check_reset_outputs();
    tick();
    rst_n = 1'b1;

    set_op(0, 40, 0, 90);
    req[0] = 1'b1;
    wait_grants(1, 10);
    wait_idle(100);
    chk("t1_id", last_id, 0);
    chk("t1_x", last_x, 0);
    chk("t1_y", last_y, 40);
    chk("t1_err", last_err, 1'b0);

    ack_log.delete();
    set_op(2, 40, 0, 180);
    req[2] = 1'b1;
    wait_idle(100);
    chk("t2_id", last_id, 2);
    chk("t2_x", last_x, -40);
    chk("t2_y", last_y, 0);

    pulse_reset();
    drop_all = 0;
    for (int k = 0; k < N; k++) set_op(k, 10 * k, -5 * k, 30 * k);
    req = 4'b1111;
    wait_grants(6, 200);
    for (int i = 0; i < 6; i++) chk("rr_order", ack_log[i], exp6[i]);
    req = 4'b1010;
    ack_log.delete();
    wait_grants(3, 200);
    for (int i = 0; i < 3; i++) chk("rr_alt", ack_log[i], exp3[i]);
    drop_all = 1;
    req = '0;
    wait_idle(200);

    ack_log.delete();
    ack_cyc.delete();
    set_op(0, -30, 25, -135);
    req[0] = 1'b1;
    wait_grants(1, 10);
    ready = 1'b0;
    wait_valid(100);
    set_op(1, 20, 20, 45);
    req[1] = 1'b1;
    repeat (10) tick();
    ready = 1'b1;
    rel = cyc;
    ack_log.delete();
    ack_cyc.delete();
    wait_grants(1, 5);
    chk("bp_grant_id", ack_log[0], 1);
    chk("bp_grant_cycle", ack_cyc[0], rel + 1);
    wait_idle(100);

    hang_mode = 1;
    ready = 1'b0;
    set_op(2, 10, 20, 45);
    req[2] = 1'b1;
    wait_valid(200);
    repeat (5) tick();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    tick();
    chk("late_done_x", ox, 0);
    chk("late_done_err", err, 1'b1);
    ready = 1'b1;
    wait_idle(100);
    hang_mode = 0;

    hang_mode = 2;
    drop_all  = 0;
    drop_rnd  = 1;
    rnd_on    = 1;
    repeat (3000) tick();
    rnd_on   = 0;
    drop_all = 1;
    ready    = 1'b1;
    wait_idle(2000);
    hang_mode = 0;
    drop_rnd  = 0;

    ack_log.delete();
    set_op(1, 30, -20, 60);
    req[1] = 1'b1;
    wait_grants(1, 10);
    repeat (5) tick();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    set_op(3, -15, 35, 120);
    req[3] = 1'b1;
    wait_grants(1, 10);
    chk("post_reset_grant", ack_log[0], 3);
    wait_idle(100);
    chk("post_reset_id", last_id, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
